udp_rx_payload_checker: RTL and testbench

Receive-side counterpart of the UDP test-pattern generator. It consumes the payload stream from the UDP/IP/MAC stack's receive port (`udp_rec_*`) and checks each packet byte by byte against the team's 20-byte test string. It reports a per-packet verdict and keeps running packet/good/error counters. With `UDP_RX_ECHO_EN` compiled in, it also buffers each received payload and hands it back to the stack's app transmit interface, giving a loopback.

---
 rtl/udp_rx_pkg.sv | 31 +++
 rtl/udp_rx_payload_checker_echo_buf.sv | 32 +++
 rtl/udp_rx_payload_checker.sv | 230 +++++++++++++++++++++++
 tb/tb_udp_rx_payload_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_pkg.sv
// Shared encodings and defaults for the UDP receive payload checker and its
// optional loopback echo path.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_RECV  = 3'b010,
    S_CHECK = 3'b100
  } chk_state_e;

  typedef enum logic [2:0] {
    E_IDLE  = 3'b001,
    E_REQ   = 3'b010,
    E_WRITE = 3'b100
  } echo_state_e;

  localparam logic [159:0] TEST_STRING   = 160'h7777772E_6D657965_73656D69_2E636F6D_2020200A;
  localparam int           HDR_BYTES_DEF = 8;

  // Byte idx of a pattern whose first byte sits in the top bits.
  function automatic logic [7:0] pattern_byte(input logic [159:0] pat, input logic [15:0] idx);
    logic [159:0] shifted;
    shifted = pat << (8 * idx);
    return shifted[159:152];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_rx_payload_checker_echo_buf.sv
// Echo payload buffer: simple dual-port byte RAM, one write port and a
// registered read port (one cycle read latency).
module udp_rx_echo_buf
  import udp_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          rgmii_clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge rgmii_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) rd_data_q <= 8'h00;
    else       rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_rx_payload_checker.sv
// UDP receive payload checker: compares each packet against the test string and
// keeps packet/good/error counters. Define UDP_RX_ECHO_EN for payload loopback.
module udp_rx_payload_checker
  import udp_rx_pkg::*;
#(
  parameter logic [159:0] EXP_PATTERN = TEST_STRING,
  parameter int           EXP_LEN     = 20,
  parameter int           HDR_BYTES   = HDR_BYTES_DEF,
  parameter int           ECHO_DEPTH  = 64
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        udp_rec_data_valid,
  input  logic [7:0]  udp_rec_rdata,
  input  logic [15:0] udp_rec_data_length,
  output logic        pkt_done,
  output logic        pkt_ok,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] last_len
`ifdef UDP_RX_ECHO_EN
  ,
  output logic        echo_data_request,
  input  logic        echo_send_ack,
  output logic        echo_data_valid,
  output logic [7:0]  echo_data,
  output logic [15:0] echo_data_length
`endif
);

  if (EXP_LEN < 1 || EXP_LEN > 20 || ECHO_DEPTH < 2 || (ECHO_DEPTH & (ECHO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("udp_rx_payload_checker: EXP_LEN must be 1..20 and ECHO_DEPTH a power of two >= 2");
  end

  chk_state_e  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        mism_q, mism_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic [15:0] rx_pkt_cnt_q, rx_pkt_cnt_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] last_len_q, last_len_d;
  logic [15:0] pay_len;
  logic        verdict;
  logic        pkt_start;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    mism_d       = mism_q;
    pkt_done_d   = 1'b0;
    pkt_ok_d     = 1'b0;
    rx_pkt_cnt_d = rx_pkt_cnt_q;
    good_cnt_d   = good_cnt_q;
    err_cnt_d    = err_cnt_q;
    last_len_d   = last_len_q;
    pkt_start    = 1'b0;
    // Short length fields wrap here and can never equal a legal byte count.
    pay_len      = len_q - 16'(HDR_BYTES);
    verdict      = !mism_q && (byte_cnt_q == 16'(EXP_LEN)) && (pay_len == byte_cnt_q);

    unique case (state_q)
      S_IDLE: begin
        if (udp_rec_data_valid) pkt_start = 1'b1;
      end
      S_RECV: begin
        if (udp_rec_data_valid) begin
          if (byte_cnt_q < 16'(EXP_LEN)) begin
            if (udp_rec_rdata != pattern_byte(EXP_PATTERN, byte_cnt_q)) mism_d = 1'b1;
          end else begin
            mism_d = 1'b1;
          end
          byte_cnt_d = sat_inc(byte_cnt_q);
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        pkt_done_d   = 1'b1;
        pkt_ok_d     = verdict;
        last_len_d   = byte_cnt_q;
        rx_pkt_cnt_d = sat_inc(rx_pkt_cnt_q);
        if (verdict) good_cnt_d = sat_inc(good_cnt_q);
        else         err_cnt_d  = sat_inc(err_cnt_q);
        if (udp_rec_data_valid) pkt_start = 1'b1;
        else                    state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pkt_start) begin
      state_d    = S_RECV;
      len_d      = udp_rec_data_length;
      byte_cnt_d = 16'd1;
      mism_d     = (udp_rec_rdata != pattern_byte(EXP_PATTERN, 16'd0));
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      byte_cnt_q   <= 16'd0;
      mism_q       <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_ok_q     <= 1'b0;
      rx_pkt_cnt_q <= 16'd0;
      good_cnt_q   <= 16'd0;
      err_cnt_q    <= 16'd0;
      last_len_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      mism_q       <= mism_d;
      pkt_done_q   <= pkt_done_d;
      pkt_ok_q     <= pkt_ok_d;
      rx_pkt_cnt_q <= rx_pkt_cnt_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
      last_len_q   <= last_len_d;
    end
  end

  assign pkt_done   = pkt_done_q;
  assign pkt_ok     = pkt_ok_q;
  assign rx_pkt_cnt = rx_pkt_cnt_q;
  assign good_cnt   = good_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign last_len   = last_len_q;

`ifdef UDP_RX_ECHO_EN
  localparam int AW = $clog2(ECHO_DEPTH);

  echo_state_e   estate_q, estate_d;
  logic          cap_q, cap_d;
  logic [15:0]   elen_q, elen_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d;
  logic          echo_start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  // The request rises on the same edge as pkt_done, so a packet starting in the
  // CHECK cycle must not capture into the buffer about to be echoed.
  assign echo_start = (state_q == S_CHECK) && cap_q &&
                      (byte_cnt_q >= 16'd1) && (byte_cnt_q <= 16'(ECHO_DEPTH));

  always_comb begin
    estate_d = estate_q;
    cap_d    = cap_q;
    elen_d   = elen_q;
    rd_cnt_d = rd_cnt_q;
    wr_en    = 1'b0;
    wr_addr  = byte_cnt_q[AW-1:0];
    rd_addr  = '0;

    if (pkt_start) begin
      cap_d   = (estate_q == E_IDLE) && !echo_start;
      wr_en   = cap_d;
      wr_addr = '0;
    end else if (state_q == S_RECV && udp_rec_data_valid && cap_q &&
                 byte_cnt_q < 16'(ECHO_DEPTH)) begin
      wr_en = 1'b1;
    end else if (state_q == S_CHECK) begin
      cap_d = 1'b0;
    end

    unique case (estate_q)
      E_IDLE: begin
        if (echo_start) begin
          estate_d = E_REQ;
          elen_d   = byte_cnt_q;
        end
      end
      E_REQ: begin
        if (echo_send_ack) begin
          estate_d = E_WRITE;
          rd_cnt_d = 16'd0;
        end
      end
      E_WRITE: begin
        // Read address leads the output byte by one to absorb RAM latency.
        rd_addr  = rd_cnt_q[AW-1:0] + AW'(1);
        rd_cnt_d = rd_cnt_q + 16'd1;
        if (rd_cnt_q == elen_q - 16'd1) estate_d = E_IDLE;
      end
      default: estate_d = E_IDLE;
    endcase
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      estate_q <= E_IDLE;
      cap_q    <= 1'b0;
      elen_q   <= 16'd0;
      rd_cnt_q <= 16'd0;
    end else begin
      estate_q <= estate_d;
      cap_q    <= cap_d;
      elen_q   <= elen_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  udp_rx_echo_buf #(
    .DEPTH (ECHO_DEPTH),
    .AW    (AW)
  ) u_echo_buf (
    .rgmii_clk (rgmii_clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (udp_rec_rdata),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  assign echo_data_request = (estate_q == E_REQ);
  assign echo_data_valid   = (estate_q == E_WRITE);
  assign echo_data         = rd_data;
  assign echo_data_length  = elen_q;
`endif

endmodule

// File: tb/tb_udp_rx_payload_checker.sv
// Directed bench for udp_rx_payload_checker: vector table of single packets plus
// hand-written back-to-back, mid-packet reset and (with UDP_RX_ECHO_EN) echo sequences.
module tb_udp_rx_payload_checker;

  localparam logic [159:0] PAT = 160'h7777772E_6D657965_73656D69_2E636F6D_2020200A;

  logic        clk;
  logic        rstn;
  logic        valid;
  logic [7:0]  rdata;
  logic [15:0] dlen;
  logic        pkt_done;
  logic        pkt_ok;
  logic [15:0] rx_pkt_cnt;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;
  logic [15:0] last_len;
`ifdef UDP_RX_ECHO_EN
  logic        echo_data_request;
  logic        echo_send_ack;
  logic        echo_data_valid;
  logic [7:0]  echo_data;
  logic [15:0] echo_data_length;
`endif

  udp_rx_payload_checker dut (
    .rgmii_clk           (clk),
    .rstn                (rstn),
    .udp_rec_data_valid  (valid),
    .udp_rec_rdata       (rdata),
    .udp_rec_data_length (dlen),
    .pkt_done            (pkt_done),
    .pkt_ok              (pkt_ok),
    .rx_pkt_cnt          (rx_pkt_cnt),
    .good_cnt            (good_cnt),
    .err_cnt             (err_cnt),
    .last_len            (last_len)
`ifdef UDP_RX_ECHO_EN
    ,
    .echo_data_request   (echo_data_request),
    .echo_send_ack       (echo_send_ack),
    .echo_data_valid     (echo_data_valid),
    .echo_data           (echo_data),
    .echo_data_length    (echo_data_length)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int exp_rx   = 0;
  int exp_good = 0;
  int exp_err  = 0;

  always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    int          n;
    int          cidx;
    logic [7:0]  cval;
    logic [15:0] len;
    logic        ok;
    logic [15:0] last;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int i);
    logic [159:0] s;
    s = PAT << (8 * i);
    return s[159:152];
  endfunction

  function automatic logic [7:0] stim_byte(input int i, input int cidx, input logic [7:0] cval);
    if (i == cidx) return cval;
    if (i < 20)    return pat_byte(i);
    return 8'h55;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the edge sampling the last byte, valid low.
  task automatic drive_bytes(input int n, input int cidx, input logic [7:0] cval, input logic [15:0] len);
    dlen = len;
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      rdata = stim_byte(i, cidx, cval);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    rdata = 8'h00;
  endtask

  task automatic run_pkt(input string name, input int n, input int cidx, input logic [7:0] cval,
                         input logic [15:0] len, input logic ok, input logic [15:0] last);
    drive_bytes(n, cidx, cval, len);
    @(posedge clk); #1;
    check({name, " done@N+1"}, {31'd0, pkt_done}, 32'd0);
    @(posedge clk); #1;
    check({name, " done@N+2"}, {31'd0, pkt_done}, 32'd1);
    check({name, " pkt_ok"}, {31'd0, pkt_ok}, {31'd0, ok});
    check({name, " last_len"}, {16'd0, last_len}, {16'd0, last});
    exp_rx++;
    if (ok) exp_good++; else exp_err++;
    check({name, " rx_pkt_cnt"}, {16'd0, rx_pkt_cnt}, exp_rx);
    check({name, " good_cnt"}, {16'd0, good_cnt}, exp_good);
    check({name, " err_cnt"}, {16'd0, err_cnt}, exp_err);
    @(posedge clk); #1;
    check({name, " done@N+3"}, {31'd0, pkt_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " pkt_done"}, {31'd0, pkt_done}, 32'd0);
    check({name, " pkt_ok"}, {31'd0, pkt_ok}, 32'd0);
    check({name, " rx_pkt_cnt"}, {16'd0, rx_pkt_cnt}, 32'd0);
    check({name, " good_cnt"}, {16'd0, good_cnt}, 32'd0);
    check({name, " err_cnt"}, {16'd0, err_cnt}, 32'd0);
    check({name, " last_len"}, {16'd0, last_len}, 32'd0);
`ifdef UDP_RX_ECHO_EN
    check({name, " echo_req"}, {31'd0, echo_data_request}, 32'd0);
    check({name, " echo_valid"}, {31'd0, echo_data_valid}, 32'd0);
    check({name, " echo_len"}, {16'd0, echo_data_length}, 32'd0);
`endif
  endtask

  initial begin
    int done_before;

    //             n   cidx  cval   len     ok    last
    vecs[0] = '{20, -1, 8'h00, 16'd28, 1'b1, 16'd20}; // exact string
    vecs[1] = '{20,  5, 8'h00, 16'd28, 1'b0, 16'd20}; // byte 5 corrupted
    vecs[2] = '{20, -1, 8'h00, 16'd30, 1'b0, 16'd20}; // length field too big
    vecs[3] = '{21, -1, 8'h00, 16'd29, 1'b0, 16'd21}; // pattern + 0x55
    vecs[4] = '{19, -1, 8'h00, 16'd27, 1'b0, 16'd19}; // short, consistent length
    vecs[5] = '{20, -1, 8'h00, 16'd4,  1'b0, 16'd20}; // length < header wraps
    vecs[6] = '{ 1, -1, 8'h00, 16'd9,  1'b0, 16'd1};  // single byte
    vecs[7] = '{20, 19, 8'h0B, 16'd28, 1'b0, 16'd20}; // last byte corrupted
    vecs[8] = '{20,  0, 8'h78, 16'd28, 1'b0, 16'd20}; // first byte corrupted

    rstn  = 1'b0;
    valid = 1'b0;
    rdata = 8'h00;
    dlen  = 16'd0;
`ifdef UDP_RX_ECHO_EN
    echo_send_ack = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      run_pkt($sformatf("vec%0d", v), vecs[v].n, vecs[v].cidx, vecs[v].cval,
              vecs[v].len, vecs[v].ok, vecs[v].last);
      @(posedge clk); #1;
    end

    // Two good packets separated by one idle cycle.
    done_before = done_cnt;
    drive_bytes(20, -1, 8'h00, 16'd28);
    @(posedge clk); #1;
    drive_bytes(20, -1, 8'h00, 16'd28);
    repeat (3) begin @(posedge clk); #1; end
    exp_rx += 2;
    exp_good += 2;
    check("b2b done pulses", done_cnt - done_before, 32'd2);
    check("b2b rx_pkt_cnt", {16'd0, rx_pkt_cnt}, exp_rx);
    check("b2b good_cnt", {16'd0, good_cnt}, exp_good);
    check("b2b last_len", {16'd0, last_len}, 32'd20);

    // Reset in the middle of a third packet: discarded, no pulse.
    dlen = 16'd28;
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1;
      rdata = pat_byte(i);
      @(posedge clk); #1;
    end
    check("midrst rx_pkt_cnt before", {16'd0, rx_pkt_cnt}, exp_rx);
    done_before = done_cnt;
    rstn  = 1'b0;
    valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check_all_zero("midrst");
    repeat (5) begin @(posedge clk); #1; end
    check("midrst no pkt_done", done_cnt - done_before, 32'd0);
    check("midrst rx stays 0", {16'd0, rx_pkt_cnt}, 32'd0);
    exp_rx = 0;
    exp_good = 0;
    exp_err = 0;

`ifdef UDP_RX_ECHO_EN
    begin
      int vcount;
      int first_k;
      int last_k;
      int req_seen;
      run_pkt("echo pkt", 20, -1, 8'h00, 16'd28, 1'b1, 16'd20);
      check("echo request", {31'd0, echo_data_request}, 32'd1);
      check("echo length", {16'd0, echo_data_length}, 32'd20);
      @(posedge clk); #1;
      echo_send_ack = 1'b1;
      @(posedge clk); #1;
      echo_send_ack = 1'b0;
      vcount = 0;
      first_k = -1;
      last_k = -1;
      req_seen = 0;
      fork
        begin
          for (int k = 0; k < 60; k++) begin
            if (echo_data_valid === 1'b1) begin
              if (first_k < 0) first_k = k;
              last_k = k;
              if (vcount < 20) check($sformatf("echo byte%0d", vcount), {24'd0, echo_data}, {24'd0, pat_byte(vcount)});
              if (echo_data_length !== 16'd20) check("echo length stable", {16'd0, echo_data_length}, 32'd20);
              vcount++;
            end
            if (echo_data_request === 1'b1) req_seen++;
            @(posedge clk); #1;
          end
        end
        begin
          repeat (2) begin @(posedge clk); #1; end
          run_pkt("echo busy pkt", 20, -1, 8'h00, 16'd28, 1'b1, 16'd20);
        end
      join
      check("echo valid count", vcount, 32'd20);
      check("echo first cycle", first_k, 32'd0);
      check("echo contiguous", last_k - first_k + 1, 32'd20);
      check("echo busy not echoed", req_seen, 32'd0);

      req_seen = 0;
      fork
        run_pkt("oversize", 65, -1, 8'h00, 16'd73, 1'b0, 16'd65);
        for (int k = 0; k < 90; k++) begin
          @(posedge clk); #1;
          if (echo_data_request === 1'b1) req_seen++;
        end
      join
      check("oversize no request", req_seen, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
